codificador: RTL and testbench
==============================

// Module: codificador
// PURPOSE
//   Parameterised priority encoder: reports the index of the most-significant
//   set bit of a one-hot or multi-hot request vector, plus a "group valid" flag.
//   Combinational result is available with zero latency for glue logic.
//   A registered copy is available for timing-critical consumers such as
//   interrupt/arbiter front-ends.
// PARAMETERS
//   WIDTH   8                 number of request inputs (>= 2)
//   OW      $clog2(WIDTH)     index width, derived (localparam, not overridable)
// PORTS
//   clk     in   1      system clock, rising edge
//   rst     in   1      synchronous, active-high reset
//   i       in   WIDTH  request vector; bit k = request k
//   o       out  OW     combinational index of highest set bit of i
//   g       out  1      combinational group flag: 1 when any bit of i is set
//   o_q     out  OW     o registered on clk
//   g_q     out  1      g registered on clk
// BEHAVIOUR
//   - Clocking: one clock (clk); reset is synchronous and active-high (rst).
//   - Combinational path (o, g): no clock dependence, settles within the same
//     delta/cycle as i; must work with clk idle and rst never asserted.
//   - g = |i.
//   - o = largest k such that i[k]=1 (MSB has highest priority); lower set bits
//     are ignored.
//   - i == 0: o = 0, g = 0 (o=0 with g=0 is distinct from i=1: o=0, g=1).
//   - No X/Z propagation for defined i; all outputs fully defined 0/1.
//   - Registered path: at each rising clk, o_q <= o, g_q <= g (1-cycle latency).
//   - rst=1 at rising clk: o_q <= 0, g_q <= 0; rst has priority over the
//     update. Combinational o/g are unaffected by rst.
//   - Reset deasserted mid-stream: first edge with rst=0 captures current i.
//   - Power-up before first reset: o_q/g_q undefined; consumers must reset.
//   - Implementation: generic loop/priority scan over WIDTH, no hard-coded case
//     table; must elaborate for WIDTH = 2, 8, 16, 32.
// TESTING
//   - i=8'b00000000 -> o=0, g=0 (combinational, no clock applied).
//   - i=8'b00000001 -> o=0, g=1; i=8'b10000000 -> o=7, g=1.
//   - Multi-hot: i=8'b00010001 -> o=4; i=8'b01001000 -> o=6;
//     i=8'b00100101 -> o=5; g=1 for all three.
//   - Registered: i=8'b00100101, one clk edge, rst=0 -> o_q=5, g_q=1;
//     change i to 0 -> o_q/g_q stay 5/1 until the next edge, then 0/0.
//   - Reset: rst=1 with i=8'hFF -> after edge o_q=0, g_q=0 while o=7, g=1;
//     deassert rst -> next edge o_q=7, g_q=1.
//   - Exhaustive sweep of all 256 values of i vs. reference model
//     (highest set bit); repeat with WIDTH=16 random vectors.

Source files
------------

// File: rtl/codificador.sv
//------------------------------------------------------------------------------
// codificador: MSB-priority encoder with zero-latency and registered outputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module codificador #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         i,
  output logic [$clog2(WIDTH)-1:0] o,
  output logic                     g,
  output logic [$clog2(WIDTH)-1:0] o_q,
  output logic                     g_q
);

  localparam int OW = $clog2(WIDTH);

  logic [OW-1:0] w_idx;
  logic          w_any;
  logic [OW-1:0] r_o_q;
  logic          r_g_q;

  // Ascending scan: each later set bit overwrites, so the highest one wins.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i[k]) begin
        w_idx = OW'(k);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_q <= '0;
      r_g_q <= 1'b0;
    end else begin
      r_o_q <= w_idx;
      r_g_q <= w_any;
    end
  end

  assign o   = w_idx;
  assign g   = w_any;
  assign o_q = r_o_q;
  assign g_q = r_g_q;

endmodule

`default_nettype wire

// File: tb/tb_codificador.sv
//------------------------------------------------------------------------------
// tb_codificador: checks the encoder against a highest-set-bit model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_codificador;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [7:0]  i8;
  logic [2:0]  o8, o8_q;
  logic        g8, g8_q;
  logic [15:0] i16;
  logic [3:0]  o16, o16_q;
  logic        g16, g16_q;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] exp8_q_o, exp16_q_o;
  logic       exp8_q_g, exp16_q_g;
  logic       q_valid = 1'b0;

  codificador #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i(i8), .o(o8), .g(g8), .o_q(o8_q), .g_q(g8_q)
  );

  codificador #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .i(i16), .o(o16), .g(g16), .o_q(o16_q), .g_q(g16_q)
  );

  // Highest set bit index via floor(log2(v)); zero maps to zero.
  function automatic logic [4:0] hb(input logic [31:0] v);
    if (v == 0) return 5'd0;
    return 5'($clog2(v + 32'd1) - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Reference for the registered path, updated on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp8_q_o  = 0; exp8_q_g  = 0;
      exp16_q_o = 0; exp16_q_g = 0;
      q_valid   = 1'b1;
    end else begin
      exp8_q_o  = hb({24'd0, i8});  exp8_q_g  = |i8;
      exp16_q_o = hb({16'd0, i16}); exp16_q_g = |i16;
    end
  end

  // Compare process: every falling edge checks all outputs against the model.
  always @(negedge clk) begin
    chk("o8_cmb",  int'(o8),  int'(hb({24'd0, i8})));
    chk("g8_cmb",  int'(g8),  int'(|i8));
    chk("o16_cmb", int'(o16), int'(hb({16'd0, i16})));
    chk("g16_cmb", int'(g16), int'(|i16));
    if (q_valid) begin
      chk("o8_q",  int'(o8_q),  int'(exp8_q_o));
      chk("g8_q",  int'(g8_q),  int'(exp8_q_g));
      chk("o16_q", int'(o16_q), int'(exp16_q_o));
      chk("g16_q", int'(g16_q), int'(exp16_q_g));
    end
  end

  initial begin
    clk_en = 1'b0;
    rst    = 1'b0;
    i8     = 8'd0;
    i16    = 16'd0;

    // Pure combinational checks, clock idle and reset never asserted.
    #1; chk("zero_o", int'(o8), 0); chk("zero_g", int'(g8), 0);
    i8 = 8'b00000001; #1; chk("lsb_o", int'(o8), 0); chk("lsb_g", int'(g8), 1);
    i8 = 8'b10000000; #1; chk("msb_o", int'(o8), 7); chk("msb_g", int'(g8), 1);
    i8 = 8'b00010001; #1; chk("mh1_o", int'(o8), 4); chk("mh1_g", int'(g8), 1);
    i8 = 8'b01001000; #1; chk("mh2_o", int'(o8), 6); chk("mh2_g", int'(g8), 1);
    i8 = 8'b00100101; #1; chk("mh3_o", int'(o8), 5); chk("mh3_g", int'(g8), 1);
    i16 = 16'h8001;   #1; chk("w16_msb", int'(o16), 15);
    i16 = 16'h0400;   #1; chk("w16_mid", int'(o16), 10);
    // Pin the model itself.
    chk("model_0",   int'(hb(32'd0)),      0);
    chk("model_25",  int'(hb(32'h25)),     5);
    chk("model_ff",  int'(hb(32'hFF)),     7);
    chk("model_fff", int'(hb(32'hFFFF)),   15);

    clk_en = 1'b1;
    rst = 1'b1; i8 = 8'd0; i16 = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Registered path holds until the next edge.
    i8 = 8'b00100101;
    @(posedge clk); #1;
    chk("reg_o", int'(o8_q), 5); chk("reg_g", int'(g8_q), 1);
    i8 = 8'd0; #1;
    chk("hold_o", int'(o8_q), 5); chk("hold_g", int'(g8_q), 1);
    chk("hold_cmb_g", int'(g8), 0);
    @(posedge clk); #1;
    chk("clr_o", int'(o8_q), 0); chk("clr_g", int'(g8_q), 0);

    // Reset takes priority over capture; combinational path is unaffected.
    i8 = 8'hFF; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_oq", int'(o8_q), 0); chk("rst_gq", int'(g8_q), 0);
    chk("rst_o",  int'(o8), 7);   chk("rst_g",  int'(g8), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_oq", int'(o8_q), 7); chk("post_rst_gq", int'(g8_q), 1);

    // Exhaustive 8-bit sweep; the compare process checks every cycle.
    for (int v = 0; v < 256; v++) begin
      i8  = 8'(v);
      i16 = 16'($urandom_range(0, 65535));
      #1;
      chk("sweep_o", int'(o8), int'(hb(32'(v))));
      @(posedge clk); #1;
    end

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 300; n++) begin
      i8  = ($urandom % 8 == 0) ? 8'd0  : 8'($urandom);
      i16 = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom >> ($urandom % 16));
      rst = ($urandom % 12 == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
